// File: rtl/stack_cpu_controller_pkg.sv
// Shared encodings for the stack-machine controller: opcodes, ALU ops, FSM states
// and the per-state control word decoder.
package stack_cpu_pkg;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_AND  = 3'b010,
        OP_NOT  = 3'b011,
        OP_PUSH = 3'b100,
        OP_POP  = 3'b101,
        OP_JMP  = 3'b110,
        OP_JZ   = 3'b111
    } opcode_e;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_NOT = 2'b11
    } alu_op_e;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_POP_A,
        S_POP_B,
        S_EXEC,
        S_MEM_RD,
        S_PUSH_MDR,
        S_MEM_WR,
        S_POP_STK,
        S_JMP,
        S_JZ
    } ctrl_state_e;

    typedef struct packed {
        logic    addr_src;
        logic    mem_read;
        logic    mem_write;
        logic    ir_write;
        logic    mdr_en;
        logic    pc_write;
        logic    jump;
        logic    load_a;
        logic    load_b;
        logic    pop;
        logic    push;
        logic    stack_src;
        alu_op_e alu_control;
        logic    instr_done;
        logic    busy;
    } ctrl_out_t;

    // JZ's conditional PC load depends on live tos, so it is not part of this word.
    function automatic ctrl_out_t decode_outputs(ctrl_state_e s, logic [2:0] op);
        ctrl_out_t o;
        o      = '0;
        o.busy = (s != S_IDLE);
        case (s)
            S_FETCH: begin
                o.mem_read = 1'b1;
                o.ir_write = 1'b1;
                o.pc_write = 1'b1;
            end
            S_POP_A: begin
                o.load_a = 1'b1;
                o.pop    = 1'b1;
            end
            S_POP_B: begin
                o.load_b = 1'b1;
                o.pop    = 1'b1;
            end
            S_EXEC: begin
                o.push        = 1'b1;
                o.alu_control = alu_op_e'(op[1:0]);
                o.instr_done  = 1'b1;
            end
            S_MEM_RD: begin
                o.addr_src = 1'b1;
                o.mem_read = 1'b1;
                o.mdr_en   = 1'b1;
            end
            S_PUSH_MDR: begin
                o.push       = 1'b1;
                o.stack_src  = 1'b1;
                o.instr_done = 1'b1;
            end
            S_MEM_WR: begin
                o.addr_src  = 1'b1;
                o.mem_write = 1'b1;
            end
            S_POP_STK: begin
                o.pop        = 1'b1;
                o.instr_done = 1'b1;
            end
            S_JMP: begin
                o.pc_write   = 1'b1;
                o.jump       = 1'b1;
                o.instr_done = 1'b1;
            end
            S_JZ: begin
                o.instr_done = 1'b1;
            end
            default: ;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/stack_cpu_controller_if.sv
// Control/status bundle between the stack-machine controller (master) and its
// datapath (slave).
interface stack_cpu_controller_if;
    logic [2:0] opcode;
    logic [7:0] tos;
    logic       addrSrc;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mdr_en;
    logic       pc_write;
    logic       jump;
    logic       load_a;
    logic       load_b;
    logic       pop;
    logic       push;
    logic       stack_src;
    logic [1:0] alu_control;
    logic       instr_done;
    logic       busy;

    modport master (
        input  opcode, tos,
        output addrSrc, mem_read, mem_write, ir_write, mdr_en, pc_write, jump,
               load_a, load_b, pop, push, stack_src, alu_control, instr_done, busy
    );

    modport slave (
        output opcode, tos,
        input  addrSrc, mem_read, mem_write, ir_write, mdr_en, pc_write, jump,
               load_a, load_b, pop, push, stack_src, alu_control, instr_done, busy
    );
endinterface

// File: rtl/stack_cpu_controller.sv
// Multicycle fetch/decode/execute controller for the 8-bit stack machine.
// Control word is registered alongside the state, so outputs are glitch-free Moore.
module stack_cpu_controller
    import stack_cpu_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      run,
    stack_cpu_controller_if.master    bus
);

    ctrl_state_e state;
    ctrl_out_t   outs;
    logic        in_jz;
    logic        jz_take;

    function automatic ctrl_state_e next_state(ctrl_state_e s, logic [2:0] op, logic go);
        ctrl_state_e n;
        n = s;
        case (s)
            S_IDLE:   n = go ? S_FETCH : S_IDLE;
            S_FETCH:  n = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_PUSH: n = S_MEM_RD;
                    OP_POP:  n = S_MEM_WR;
                    OP_JMP:  n = S_JMP;
                    OP_JZ:   n = S_JZ;
                    default: n = S_POP_A;
                endcase
            end
            S_POP_A:  n = (op == OP_NOT) ? S_EXEC : S_POP_B;
            S_POP_B:  n = S_EXEC;
            S_MEM_RD: n = S_PUSH_MDR;
            S_MEM_WR: n = S_POP_STK;
            S_EXEC, S_PUSH_MDR, S_POP_STK, S_JMP, S_JZ:
                      n = go ? S_FETCH : S_IDLE;
            default:  n = S_IDLE;
        endcase
        return n;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            outs  <= '0;
            in_jz <= 1'b0;
        end else begin
            state <= next_state(state, bus.opcode, run);
            outs  <= decode_outputs(next_state(state, bus.opcode, run), bus.opcode);
            in_jz <= (next_state(state, bus.opcode, run) == S_JZ);
        end
    end

    // JZ examines tos while in the JZ state itself; in_jz is cleared by reset.
    assign jz_take = in_jz && (bus.tos == 8'h00);

    assign bus.addrSrc     = outs.addr_src;
    assign bus.mem_read    = outs.mem_read;
    assign bus.mem_write   = outs.mem_write;
    assign bus.ir_write    = outs.ir_write;
    assign bus.mdr_en      = outs.mdr_en;
    assign bus.pc_write    = outs.pc_write | jz_take;
    assign bus.jump        = outs.jump | jz_take;
    assign bus.load_a      = outs.load_a;
    assign bus.load_b      = outs.load_b;
    assign bus.pop         = outs.pop;
    assign bus.push        = outs.push;
    assign bus.stack_src   = outs.stack_src;
    assign bus.alu_control = outs.alu_control;
    assign bus.instr_done  = outs.instr_done;
    assign bus.busy        = outs.busy;

endmodule

// File: tb/tb_stack_cpu_controller.sv
// Scoreboard bench for stack_cpu_controller: expected per-cycle control words are
// queued per scenario and compared one cycle at a time after each rising edge.
module tb_stack_cpu_controller;

    logic clk;
    logic rst;
    logic run;

    stack_cpu_controller_if bus ();

    stack_cpu_controller dut (
        .clk (clk),
        .rst (rst),
        .run (run),
        .bus (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bit order: addrSrc mem_read mem_write ir_write mdr_en pc_write jump load_a
    //            load_b pop push stack_src alu[1:0] instr_done busy
    localparam logic [15:0] V_IDLE     = 16'h0000;
    localparam logic [15:0] V_FETCH    = 16'h5401;
    localparam logic [15:0] V_DECODE   = 16'h0001;
    localparam logic [15:0] V_POP_A    = 16'h0141;
    localparam logic [15:0] V_POP_B    = 16'h00C1;
    localparam logic [15:0] V_EXEC     = 16'h0023;
    localparam logic [15:0] V_MEM_RD   = 16'hC801;
    localparam logic [15:0] V_PUSH_MDR = 16'h0033;
    localparam logic [15:0] V_MEM_WR   = 16'hA001;
    localparam logic [15:0] V_POP_STK  = 16'h0043;
    localparam logic [15:0] V_JMP      = 16'h0603;
    localparam logic [15:0] V_JZ_NT    = 16'h0003;

    typedef struct {
        string       name;
        logic [15:0] vec;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [15:0] ctrl_vec;
    assign ctrl_vec = {bus.addrSrc, bus.mem_read, bus.mem_write, bus.ir_write, bus.mdr_en,
                       bus.pc_write, bus.jump, bus.load_a, bus.load_b, bus.pop, bus.push,
                       bus.stack_src, bus.alu_control, bus.instr_done, bus.busy};

    function automatic exp_t mk(string n, logic [15:0] v);
        exp_t e;
        e.name = n;
        e.vec  = v;
        return e;
    endfunction

    function automatic logic [15:0] v_exec(logic [1:0] alu);
        return V_EXEC | {12'h000, alu, 2'b00};
    endfunction

    task automatic test_reset();
        exp_t e;
        run = 1'b1;
        rst = 1'b0;
        bus.opcode = 3'b000;
        bus.tos    = 8'h00;
        #3;
        n_checks++;
        if (ctrl_vec !== V_IDLE) begin
            n_fail++;
            $display("FAIL reset_hold: got %h expected %h", ctrl_vec, V_IDLE);
        end
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (ctrl_vec !== V_IDLE || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_run_high: got %h expected %h", ctrl_vec, V_IDLE);
        end
        @(negedge clk);
        run = 1'b0;
        rst = 1'b1;
        repeat (5) exp_q.push_back(mk("idle_no_run", V_IDLE));
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            n_checks++;
            if (ctrl_vec !== e.vec) begin
                n_fail++;
                $display("FAIL %s cycle %0d: got %h expected %h", e.name, i, ctrl_vec, e.vec);
            end
        end
    endtask

    // Starts one instruction from IDLE, drops run during FETCH, expects a trailing IDLE.
    task automatic test_single(string tag, logic [2:0] op, logic [7:0] t);
        exp_t e;
        int   n;
        exp_q.push_back(mk({tag, "_fetch"}, V_FETCH));
        exp_q.push_back(mk({tag, "_decode"}, V_DECODE));
        case (op)
            3'b000, 3'b001, 3'b010: begin
                exp_q.push_back(mk({tag, "_pop_a"}, V_POP_A));
                exp_q.push_back(mk({tag, "_pop_b"}, V_POP_B));
                exp_q.push_back(mk({tag, "_exec"}, v_exec(op[1:0])));
            end
            3'b011: begin
                exp_q.push_back(mk({tag, "_pop_a"}, V_POP_A));
                exp_q.push_back(mk({tag, "_exec"}, v_exec(2'b11)));
            end
            3'b100: begin
                exp_q.push_back(mk({tag, "_mem_rd"}, V_MEM_RD));
                exp_q.push_back(mk({tag, "_push_mdr"}, V_PUSH_MDR));
            end
            3'b101: begin
                exp_q.push_back(mk({tag, "_mem_wr"}, V_MEM_WR));
                exp_q.push_back(mk({tag, "_pop_stk"}, V_POP_STK));
            end
            3'b110:  exp_q.push_back(mk({tag, "_jmp"}, V_JMP));
            default: exp_q.push_back(mk({tag, "_jz"}, (t == 8'h00) ? V_JMP : V_JZ_NT));
        endcase
        exp_q.push_back(mk({tag, "_idle"}, V_IDLE));
        n = exp_q.size();
        @(negedge clk);
        bus.opcode = op;
        bus.tos    = t;
        run        = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (i == 0) run = 1'b0;
            e = exp_q.pop_front();
            n_checks++;
            if (ctrl_vec !== e.vec) begin
                n_fail++;
                $display("FAIL %s: got %h expected %h", e.name, ctrl_vec, e.vec);
            end
            n_checks++;
            if (bus.mem_write === 1'b1 && bus.pop === 1'b1) begin
                n_fail++;
                $display("FAIL %s_wr_pop_overlap: got mem_write=1 pop=1 expected not both", e.name);
            end
        end
    endtask

    task automatic test_run_drop();
        exp_t e;
        exp_q.push_back(mk("drop_fetch", V_FETCH));
        exp_q.push_back(mk("drop_decode", V_DECODE));
        exp_q.push_back(mk("drop_pop_a", V_POP_A));
        exp_q.push_back(mk("drop_pop_b", V_POP_B));
        exp_q.push_back(mk("drop_exec", v_exec(2'b01)));
        exp_q.push_back(mk("drop_idle", V_IDLE));
        exp_q.push_back(mk("drop_idle2", V_IDLE));
        @(negedge clk);
        bus.opcode = 3'b001;
        run        = 1'b1;
        for (int i = 0; i < 7; i++) begin
            @(posedge clk);
            #1;
            if (i == 2) run = 1'b0;
            e = exp_q.pop_front();
            n_checks++;
            if (ctrl_vec !== e.vec) begin
                n_fail++;
                $display("FAIL %s: got %h expected %h", e.name, ctrl_vec, e.vec);
            end
        end
    endtask

    // ADD then JMP with run held: second FETCH follows EXEC directly.
    task automatic test_back_to_back();
        exp_t e;
        exp_q.push_back(mk("b2b_fetch0", V_FETCH));
        exp_q.push_back(mk("b2b_decode0", V_DECODE));
        exp_q.push_back(mk("b2b_pop_a", V_POP_A));
        exp_q.push_back(mk("b2b_pop_b", V_POP_B));
        exp_q.push_back(mk("b2b_exec", v_exec(2'b00)));
        exp_q.push_back(mk("b2b_fetch1", V_FETCH));
        exp_q.push_back(mk("b2b_decode1", V_DECODE));
        exp_q.push_back(mk("b2b_jmp", V_JMP));
        exp_q.push_back(mk("b2b_idle", V_IDLE));
        @(negedge clk);
        bus.opcode = 3'b000;
        run        = 1'b1;
        for (int i = 0; i < 9; i++) begin
            @(posedge clk);
            #1;
            if (i == 5) begin
                bus.opcode = 3'b110;
                run        = 1'b0;
            end
            e = exp_q.pop_front();
            n_checks++;
            if (ctrl_vec !== e.vec) begin
                n_fail++;
                $display("FAIL %s: got %h expected %h", e.name, ctrl_vec, e.vec);
            end
        end
    endtask

    task automatic test_midop_reset();
        exp_t e;
        exp_q.push_back(mk("rst_fetch", V_FETCH));
        exp_q.push_back(mk("rst_decode", V_DECODE));
        exp_q.push_back(mk("rst_mem_wr", V_MEM_WR));
        @(negedge clk);
        bus.opcode = 3'b101;
        run        = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            n_checks++;
            if (ctrl_vec !== e.vec) begin
                n_fail++;
                $display("FAIL %s: got %h expected %h", e.name, ctrl_vec, e.vec);
            end
        end
        #1;
        rst = 1'b0;
        #1;
        n_checks++;
        if (ctrl_vec !== V_IDLE) begin
            n_fail++;
            $display("FAIL rst_async_clear: got %h expected %h", ctrl_vec, V_IDLE);
        end
        @(negedge clk);
        run = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (ctrl_vec !== V_IDLE) begin
            n_fail++;
            $display("FAIL rst_idle_after_release: got %h expected %h", ctrl_vec, V_IDLE);
        end
        @(negedge clk);
        run = 1'b1;
        @(posedge clk);
        #1;
        run = 1'b0;
        n_checks++;
        if (ctrl_vec !== V_FETCH) begin
            n_fail++;
            $display("FAIL rst_restart_fetch: got %h expected %h", ctrl_vec, V_FETCH);
        end
        repeat (4) @(posedge clk);
        #1;
        n_checks++;
        if (ctrl_vec !== V_IDLE) begin
            n_fail++;
            $display("FAIL rst_restart_idle: got %h expected %h", ctrl_vec, V_IDLE);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single("add", 3'b000, 8'h12);
        test_single("sub", 3'b001, 8'h34);
        test_single("and", 3'b010, 8'h56);
        test_single("not", 3'b011, 8'h78);
        test_single("push", 3'b100, 8'h9A);
        test_single("pop", 3'b101, 8'hBC);
        test_single("jmp", 3'b110, 8'hDE);
        test_single("jz_taken", 3'b111, 8'h00);
        test_single("jz_not", 3'b111, 8'h05);
        test_run_drop();
        test_back_to_back();
        test_midop_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
